updi_tx_frame_ctrl: RTL and testbench
=====================================

Name: updi_tx_frame_ctrl

Overview:
- Sequences one complete UPDI transmit frame onto the shared uart_tx byte transmitter.
- Frame order: optional BREAK, then SYNC (0x55), then instruction opcode, then 0..MAX_DATA_BYTES payload bytes, then an inter-frame guard time.
- Sits between the UPDI protocol engine (requester) and uart_tx. It owns uart_tx's start/tx_data inputs and watches its ready output.

Parameters:
- MAX_DATA_BYTES, 8, maximum payload bytes per frame.
- BREAK_CYCLES, 24600, clk cycles the line is held low for a BREAK.
- BREAK_GAP_CYCLES, 1200, clk cycles of idle-high after BREAK before SYNC.
- GUARD_CYCLES, 120, idle clk cycles after the last byte completes.
- WDOG_CYCLES, 4096, per-byte completion timeout; used only with the optional feature.

Ports:
- clk  in  1  logic clock (single clock domain).
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  frame request valid.
- req_ready  out  1  controller can accept a frame.
- req_break  in  1  send a BREAK before the frame.
- req_opcode  in  8  UPDI instruction byte.
- req_len  in  $clog2(MAX_DATA_BYTES+1)  payload byte count.
- req_data  in  8*MAX_DATA_BYTES  payload; byte i = req_data[8i+7:8i].
- uart_tx_data  out  8  byte presented to uart_tx.
- uart_start  out  1  one-cycle start strobe to uart_tx.
- uart_ready  in  1  uart_tx ready.
- break_active  out  1  line forced low; top level drives line = uart tx AND NOT break_active.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- error  out  1  one-cycle pulse on watchdog abort (tied 0 without the optional feature).

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, including req_ready. req_ready rises on the first clk edge after rst releases.
- All outputs are registered.
- Accept: req_valid && req_ready while in IDLE.
  - Captures opcode, data and break flag.
  - Captures len clamped to MAX_DATA_BYTES.
  - On the next cycle: req_ready=0, busy=1. State goes to BREAK if req_break, else SYNC.
- BREAK: break_active=1 for exactly BREAK_CYCLES cycles, then GAP.
- GAP: break_active=0 for BREAK_GAP_CYCLES cycles, then SYNC. uart_start stays 0 throughout BREAK and GAP.
- Byte issue sub-flow, used for SYNC, OPCODE and each DATA byte:
  - ISSUE: wait for uart_ready=1. Then assert uart_start for exactly one cycle, with uart_tx_data valid in that same cycle.
  - WAIT_LOW: wait for uart_ready=0 (uart_tx accepted the byte).
  - WAIT_HIGH: wait for uart_ready=1 (byte plus stop bits done), then advance.
- Byte order: SYNC=0x55, then opcode, then data[0] .. data[len-1].
- len=0: GUARD follows the opcode directly.
- Byte index counter: starts at 0 and increments after each data byte's WAIT_HIGH. DATA ends when index == len-1.
- GUARD: idle for GUARD_CYCLES cycles, then return to IDLE. In that transition cycle: done=1 for one cycle, busy=0, req_ready=1.
- A uart_ready glitch high during WAIT_LOW is ignored. Only the low-then-high sequence completes a byte.
- req_valid while busy is ignored; no queueing.
- Asserting rst mid-frame aborts immediately. break_active drops asynchronously. No partial done.
- Timer terminal counts of 0 mean a zero-length phase: the state advances on the next cycle.

Optional Feature:
- Macro: UPDI_TX_FRAME_WDOG_EN.
- Defined: a timer restarts on entry to WAIT_LOW. If WAIT_HIGH has not completed within WDOG_CYCLES, the controller pulses error for one cycle and goes straight to IDLE. In that cycle req_ready=1, busy=0, and done is not pulsed.
- Undefined: no timeout, no timer logic, error held 0.

Decomposition:
- Package updi_pkg holds:
  - Enum updi_tx_frame_state: IDLE, BREAK, GAP, ISSUE, WAIT_LOW, WAIT_HIGH, GUARD.
  - Enum updi_byte_sel: SYNC, OPCODE, DATA.
  - Constant UPDI_SYNC_CHAR = 8'h55.
- One sub-module, updi_cycle_timer: a loadable down-counter with a load input, a terminal-count output, and a width parameter.
  - Shared by BREAK, GAP, GUARD and the watchdog. Only one of these phases is active at a time.

Test Plan:
- req_break=0, opcode=0x80, len=0; stub uart_tx with 10-cycle busy → uart_start pulses exactly twice (0x55, 0x80); done 1 cycle after GUARD; busy high for the whole frame.
- req_break=1, BREAK_CYCLES=50, BREAK_GAP_CYCLES=20 → break_active high exactly 50 cycles; no uart_start for the following 20 cycles; then 0x55 is issued.
- len=3, data=0x33_22_11 → bytes sent in order 0x55, opcode, 0x11, 0x22, 0x33; each start occurs only after uart_ready returned high.
- len=12 with MAX=8 → exactly 8 data bytes sent; req_valid pulsed mid-frame is ignored; req_ready=1 in the cycle done=1.
- rst asserted during the 2nd data byte → all outputs 0 immediately; after release, req_ready=1 and a new frame completes normally.
- With UPDI_TX_FRAME_WDOG_EN, WDOG_CYCLES=100, stub holds uart_ready=0 → error pulses 100 cycles after start is accepted; done never asserts; controller returns to IDLE.

Source files
------------

// File: rtl/updi_tx_frame_ctrl_pkg.sv
// updi_pkg: shared state/byte-select types, the SYNC character and small
// constant helpers for the UPDI transmit frame controller.
package updi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BREAK,
    GAP,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    GUARD
  } updi_tx_frame_state;

  typedef enum logic [1:0] {
    SYNC,
    OPCODE,
    DATA
  } updi_byte_sel;

  localparam logic [7:0] UPDI_SYNC_CHAR = 8'h55;

  // Timer load value for a phase lasting 'cycles' clocks; 0 still costs one cycle.
  function automatic int unsigned updi_term_count(input int unsigned cycles);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

  function automatic int unsigned updi_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/updi_cycle_timer.sv
// updi_cycle_timer: loadable down-counter; tc_o is high while the count is zero.
module updi_cycle_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/updi_tx_frame_ctrl.sv
// updi_tx_frame_ctrl: sequences BREAK, SYNC, opcode, payload and guard time
// onto a uart_tx byte transmitter. All outputs are registered.
// Optional per-byte watchdog: define UPDI_TX_FRAME_WDOG_EN.
module updi_tx_frame_ctrl
  import updi_pkg::*;
#(
  parameter  int unsigned MAX_DATA_BYTES   = 8,
  parameter  int unsigned BREAK_CYCLES     = 24600,
  parameter  int unsigned BREAK_GAP_CYCLES = 1200,
  parameter  int unsigned GUARD_CYCLES     = 120,
  parameter  int unsigned WDOG_CYCLES      = 4096,
  localparam int unsigned LEN_W            = $clog2(MAX_DATA_BYTES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_break,
  input  logic [7:0]                  req_opcode,
  input  logic [LEN_W-1:0]            req_len,
  input  logic [8*MAX_DATA_BYTES-1:0] req_data,
  output logic [7:0]                  uart_tx_data,
  output logic                        uart_start,
  input  logic                        uart_ready,
  output logic                        break_active,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int unsigned TMR_MAX = updi_max(updi_max(BREAK_CYCLES, BREAK_GAP_CYCLES),
                                             updi_max(GUARD_CYCLES, updi_max(WDOG_CYCLES, 1)));
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] LD_BREAK = TMR_W'(updi_term_count(BREAK_CYCLES));
  localparam logic [TMR_W-1:0] LD_GAP   = TMR_W'(updi_term_count(BREAK_GAP_CYCLES));
  localparam logic [TMR_W-1:0] LD_GUARD = TMR_W'(updi_term_count(GUARD_CYCLES));
`ifdef UPDI_TX_FRAME_WDOG_EN
  localparam logic [TMR_W-1:0] LD_WDOG  = TMR_W'(updi_term_count(WDOG_CYCLES));
`endif
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_DATA_BYTES);

  updi_tx_frame_state state_q, state_d;
  updi_byte_sel       sel_q, sel_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [LEN_W-1:0]            idx_q, idx_d;
  logic [7:0]                  opcode_q, opcode_d;
  logic [8*MAX_DATA_BYTES-1:0] data_q, data_d;
  logic [8*MAX_DATA_BYTES-1:0] data_sh;
  logic [7:0]                  byte_cur;

  logic       req_ready_q, req_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       break_q, break_d;
  logic       start_q, start_d;
  logic [7:0] tx_data_q, tx_data_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_tc;

  updi_cycle_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // Select the byte for the next issue: SYNC, opcode, or payload[idx].
  always_comb begin
    data_sh  = data_q >> {idx_q, 3'b000};
    byte_cur = data_sh[7:0];
    case (sel_q)
      SYNC:    byte_cur = UPDI_SYNC_CHAR;
      OPCODE:  byte_cur = opcode_q;
      default: byte_cur = data_sh[7:0];
    endcase
  end

  // Frame sequencing; output values are computed from the next state and registered.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    len_d     = len_q;
    idx_d     = idx_q;
    opcode_d  = opcode_q;
    data_d    = data_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    start_d   = 1'b0;
    tx_data_d = tx_data_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          opcode_d = req_opcode;
          data_d   = req_data;
          len_d    = (req_len > LEN_MAX) ? LEN_MAX : req_len;
          sel_d    = SYNC;
          idx_d    = '0;
          if (req_break) begin
            state_d  = BREAK;
            tmr_load = 1'b1;
            tmr_val  = LD_BREAK;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      BREAK: begin
        if (tmr_tc) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = LD_GAP;
        end
      end

      GAP: begin
        if (tmr_tc) begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (uart_ready) begin
          start_d   = 1'b1;
          tx_data_d = byte_cur;
          state_d   = WAIT_LOW;
`ifdef UPDI_TX_FRAME_WDOG_EN
          tmr_load  = 1'b1;
          tmr_val   = LD_WDOG;
`endif
        end
      end

      WAIT_LOW: begin
`ifdef UPDI_TX_FRAME_WDOG_EN
        if (tmr_tc) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else
`endif
        if (!uart_ready) begin
          state_d = WAIT_HIGH;
        end
      end

      WAIT_HIGH: begin
        if (uart_ready) begin
          case (sel_q)
            SYNC: begin
              sel_d   = OPCODE;
              state_d = ISSUE;
            end
            OPCODE: begin
              if (len_q == '0) begin
                state_d  = GUARD;
                tmr_load = 1'b1;
                tmr_val  = LD_GUARD;
              end else begin
                sel_d   = DATA;
                state_d = ISSUE;
              end
            end
            default: begin
              if (idx_q == len_q - 1'b1) begin
                state_d  = GUARD;
                tmr_load = 1'b1;
                tmr_val  = LD_GUARD;
              end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ISSUE;
              end
            end
          endcase
        end
`ifdef UPDI_TX_FRAME_WDOG_EN
        else if (tmr_tc) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
`endif
      end

      GUARD: begin
        if (tmr_tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    break_d     = (state_d == BREAK);
  end

  // State, captured request and registered outputs; reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sel_q       <= SYNC;
      len_q       <= '0;
      idx_q       <= '0;
      opcode_q    <= '0;
      data_q      <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      break_q     <= 1'b0;
      start_q     <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      opcode_q    <= opcode_d;
      data_q      <= data_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      break_q     <= break_d;
      start_q     <= start_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign break_active = break_q;
  assign uart_start   = start_q;
  assign uart_tx_data = tx_data_q;

endmodule

// File: tb/tb_updi_tx_frame_ctrl.sv
// Bench for updi_tx_frame_ctrl: stub uart_tx (10-cycle busy per byte) and a
// byte scoreboard filled when requests are driven, drained on uart_start.
module tb_updi_tx_frame_ctrl;

  localparam int unsigned MAXB  = 8;
  localparam int unsigned BRK   = 50;
  localparam int unsigned GAPC  = 20;
  localparam int unsigned GRD   = 12;
  localparam int unsigned WDOG  = 100;
  localparam int unsigned LEN_W = $clog2(MAXB + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_break = 1'b0;
  logic [7:0]        req_opcode = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic [8*MAXB-1:0] req_data = '0;
  logic [7:0]        uart_tx_data;
  logic              uart_start;
  logic              uart_ready = 1'b1;
  logic              break_active;
  logic              busy;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int last_rise = 0;
  int stub_cnt = 0;
  int err_pulses = 0;
  bit stub_stuck = 1'b0;
  logic [7:0] exp_q[$];

  updi_tx_frame_ctrl #(
    .MAX_DATA_BYTES   (MAXB),
    .BREAK_CYCLES     (BRK),
    .BREAK_GAP_CYCLES (GAPC),
    .GUARD_CYCLES     (GRD),
    .WDOG_CYCLES      (WDOG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_break    (req_break),
    .req_opcode   (req_opcode),
    .req_len      (req_len),
    .req_data     (req_data),
    .uart_tx_data (uart_tx_data),
    .uart_start   (uart_start),
    .uart_ready   (uart_ready),
    .break_active (break_active),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // uart_tx stub plus scoreboard drain.
  always @(negedge clk) begin
    logic [7:0] e;
    if (error === 1'b1) err_pulses++;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0 && !stub_stuck) begin
        uart_ready = 1'b1;
        last_rise  = cyc;
      end
    end
    if (uart_start === 1'b1) begin
      starts++;
      checks++;
      if (uart_ready !== 1'b1) begin
        errors++;
        $display("FAIL start_before_ready: uart_ready=%b required 1 (cyc %0d)", uart_ready, cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h, none expected", uart_tx_data);
      end else begin
        e = exp_q.pop_front();
        if (uart_tx_data !== e) begin
          errors++;
          $display("FAIL byte_order: got %02h required %02h", uart_tx_data, e);
        end
      end
      uart_ready = 1'b0;
      stub_cnt   = 10;
    end
  end

  task automatic issue(input bit brk, input logic [7:0] opc, input int len, input logic [63:0] data);
    int n;
    int waited = 0;
    while (req_ready !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: req_ready=%b required 1", req_ready);
    end
    n = (len > 8) ? 8 : len;
    exp_q.push_back(8'h55);
    exp_q.push_back(opc);
    for (int i = 0; i < n; i++) exp_q.push_back(data[8*i +: 8]);
    req_break  = brk;
    req_opcode = opc;
    req_len    = LEN_W'(len);
    req_data   = data;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    req_break  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output int busy_low, output int done_cyc);
    got = 1'b0;
    busy_low = 0;
    done_cyc = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (busy !== 1'b1) busy_low++;
    end
  endtask

  task automatic test_reset;
    logic [14:0] outs;
    #1 rst = 1'b0;
    #1;
    outs = {req_ready, busy, done, error, break_active, uart_start, uart_tx_data};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: req_ready=%b required 1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit got;
    int bl, dc, s0;
    s0 = starts;
    issue(1'b0, 8'h80, 0, 64'h0);
    wait_done(3000, got, bl, dc);
    checks++;
    if (!got) begin errors++; $display("FAIL basic_done: done not seen, required 1"); end
    checks++;
    if (bl != 0) begin errors++; $display("FAIL basic_busy: busy low %0d cycles, required 0", bl); end
    checks++;
    if (starts - s0 != 2) begin errors++; $display("FAIL basic_starts: got %0d required 2", starts - s0); end
    checks++;
    if (dc - last_rise != GRD + 1) begin
      errors++;
      $display("FAIL basic_guard: done %0d cycles after last ready, required %0d", dc - last_rise, GRD + 1);
    end
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL basic_done_cycle: ready/busy=%b required 10", {req_ready, busy});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: done=%b required 0", done); end
  endtask

  task automatic test_break;
    int brk_hi, last_brk, first_st, s0;
    bit got;
    s0 = starts;
    first_st = -1;
    last_brk = -1;
    issue(1'b1, 8'h20, 0, 64'h0);
    brk_hi = (break_active === 1'b1) ? 1 : 0;
    if (break_active === 1'b1) last_brk = cyc;
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (break_active === 1'b1) begin brk_hi++; last_brk = cyc; end
      if (uart_start === 1'b1 && first_st < 0) first_st = cyc;
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    checks++;
    if (brk_hi != BRK) begin errors++; $display("FAIL break_len: got %0d required %0d", brk_hi, BRK); end
    checks++;
    if (first_st - last_brk != GAPC + 2) begin
      errors++;
      $display("FAIL break_gap: first start %0d cycles after break, required %0d", first_st - last_brk, GAPC + 2);
    end
    checks++;
    if (!got || starts - s0 != 2) begin
      errors++;
      $display("FAIL break_frame: done=%b starts=%0d required 1/2", got, starts - s0);
    end
  endtask

  task automatic test_data;
    bit got;
    int bl, dc, s0;
    s0 = starts;
    issue(1'b0, 8'h44, 3, 64'h0000_0000_0033_2211);
    wait_done(3000, got, bl, dc);
    checks++;
    if (!got || starts - s0 != 5) begin
      errors++;
      $display("FAIL data_frame: done=%b starts=%0d required 1/5", got, starts - s0);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL data_drain: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_clamp;
    bit got;
    int bl, dc, s0, s1;
    s0 = starts;
    issue(1'b0, 8'hA5, 12, 64'h8877_6655_4433_2211);
    repeat (30) @(negedge clk);
    req_valid  = 1'b1;
    req_break  = 1'b1;
    req_opcode = 8'hEE;
    req_len    = LEN_W'(1);
    @(negedge clk);
    req_valid  = 1'b0;
    req_break  = 1'b0;
    wait_done(5000, got, bl, dc);
    checks++;
    if (!got || starts - s0 != 10) begin
      errors++;
      $display("FAIL clamp_frame: done=%b starts=%0d required 1/10", got, starts - s0);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL clamp_ready_at_done: req_ready=%b required 1", req_ready); end
    s1 = starts;
    repeat (40) @(negedge clk);
    checks++;
    if (starts != s1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clamp_no_queue: extra starts %0d busy=%b required 0/0", starts - s1, busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [14:0] outs;
    bit got;
    int bl, dc, s0, k;
    s0 = starts;
    issue(1'b0, 8'h33, 4, 64'h0000_0000_DDCC_BBAA);
    k = 0;
    while (starts - s0 < 4 && k < 2000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    outs = {req_ready, busy, done, error, break_active, uart_start, uart_tx_data};
    checks++;
    if (outs !== '0 || starts - s0 != 4) begin
      errors++;
      $display("FAIL reset_mid: outs=%h starts=%0d required 0/4", outs, starts - s0);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ready: ready/done=%b required 10", {req_ready, done});
    end
    @(negedge clk);
    s0 = starts;
    issue(1'b0, 8'h66, 2, 64'h0201);
    wait_done(3000, got, bl, dc);
    checks++;
    if (!got || starts - s0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_recover: done=%b starts=%0d left=%0d required 1/4/0", got, starts - s0, exp_q.size());
    end
  endtask

`ifdef UPDI_TX_FRAME_WDOG_EN
  task automatic test_wdog;
    int st, ec, dn;
    bit seen;
    st = -1; ec = -1; dn = 0; seen = 1'b0;
    stub_stuck = 1'b1;
    issue(1'b0, 8'h90, 0, 64'h0);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (uart_start === 1'b1 && st < 0) st = cyc;
      if (done === 1'b1) dn++;
      if (error === 1'b1) begin
        ec = cyc;
        seen = 1'b1;
        checks++;
        if ({req_ready, busy, done} !== 3'b100) begin
          errors++;
          $display("FAIL wdog_state: ready/busy/done=%b required 100", {req_ready, busy, done});
        end
        break;
      end
    end
    checks++;
    if (!seen || ec - st != WDOG) begin
      errors++;
      $display("FAIL wdog_time: seen=%b delay=%0d required 1/%0d", seen, ec - st, WDOG);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b0 || dn != 0) begin
      errors++;
      $display("FAIL wdog_pulse: error=%b done_pulses=%0d required 0/0", error, dn);
    end
    exp_q.delete();
    stub_stuck = 1'b0;
    uart_ready = 1'b1;
    repeat (12) @(negedge clk);
  endtask
`else
  task automatic test_no_error;
    checks++;
    if (err_pulses != 0) begin
      errors++;
      $display("FAIL error_tied: %0d pulses, required 0", err_pulses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_data();
    test_clamp();
    test_reset_mid();
`ifdef UPDI_TX_FRAME_WDOG_EN
    test_wdog();
`else
    test_no_error();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
